// File: rtl/calculator_pkg.sv
// Shared widths and the result-buffer state type for the calculator datapath.
// Also holds the small helpers the buffer FSM uses to decode its state.
package calculator_pkg;

    localparam int DATA_W        = 32;
    localparam int MEM_WORD_SIZE = 64;
    localparam int ADDR_W        = 16;

    typedef enum logic [1:0] {
        S_EMPTY = 2'b00,
        S_LO    = 2'b01,
        S_HI    = 2'b10,
        S_FULL  = 2'b11
    } buf_state_t;

    // State reached from an empty buffer when a result lands in the chosen half.
    function automatic buf_state_t fill_target(input logic upper);
        return upper ? S_HI : S_LO;
    endfunction

    // True when the chosen half already holds a result in a partial word.
    function automatic logic half_taken(input buf_state_t st, input logic upper);
        return (st == S_LO && !upper) || (st == S_HI && upper);
    endfunction

endpackage

// File: rtl/result_buffer_if.sv
// Adder-result handshake plus packed-word/ack handshake of the result buffer.
// slave = the buffer itself, master = the adder/controller side driving it.
interface result_buffer_if #(
    parameter int DATA_W        = calculator_pkg::DATA_W,
    parameter int MEM_WORD_SIZE = calculator_pkg::MEM_WORD_SIZE
);
    logic                     res_valid_i;
    logic                     res_ready_o;
    logic [DATA_W-1:0]        res_i;
    logic                     carry_i;
    logic                     buffer_control_i;
    logic [MEM_WORD_SIZE-1:0] buff_result_o;
    logic                     word_valid_o;
    logic                     word_ack_i;
    logic [1:0]               carry_o;
    logic                     err_o;

    modport slave (
        input  res_valid_i, res_i, carry_i, buffer_control_i, word_ack_i,
        output res_ready_o, buff_result_o, word_valid_o, carry_o, err_o
    );

    modport master (
        output res_valid_i, res_i, carry_i, buffer_control_i, word_ack_i,
        input  res_ready_o, buff_result_o, word_valid_o, carry_o, err_o
    );
endinterface

// File: rtl/result_buffer_buffer_half.sv
// One half of the packed word: data register plus its carry bit.
// Clear drops only the carry; load wins over clear so an ack+accept refills cleanly.
module buffer_half #(
    parameter int WIDTH = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             clr,
    input  logic             load,
    input  logic [WIDTH-1:0] data_in,
    input  logic             carry_in,
    output logic [WIDTH-1:0] data,
    output logic             carry
);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            data  <= '0;
            carry <= 1'b0;
        end else if (load) begin
            data  <= data_in;
            carry <= carry_in;
        end else if (clr) begin
            carry <= 1'b0;
        end
    end

endmodule

// File: rtl/result_buffer.sv
// Packs two adder results into one memory word, tracking per-half carry-out,
// and holds the word until the controller acknowledges the write.
module result_buffer
    import calculator_pkg::*;
(
    input  logic           clk_i,
    input  logic           rst_i,
    result_buffer_if.slave bus
);

    buf_state_t        state;
    logic              ready;
    logic              accept;
    logic              ack_full;
    logic              upper;
    logic              dup;
    logic              load_lo;
    logic              load_hi;
    logic              err;
    logic [DATA_W-1:0] lo_data;
    logic [DATA_W-1:0] hi_data;
    logic              lo_carry;
    logic              hi_carry;

    generate
        if (MEM_WORD_SIZE != 2 * DATA_W) begin : g_width_check
            $error("MEM_WORD_SIZE must be twice DATA_W");
        end
    endgenerate

    // Ready depends only on state and ack, never on res_valid_i.
    assign ready    = (state != S_FULL) || bus.word_ack_i;
    assign accept   = bus.res_valid_i && ready;
    assign ack_full = (state == S_FULL) && bus.word_ack_i;
    assign upper    = bus.buffer_control_i;
    assign dup      = accept && half_taken(state, upper);
    assign load_lo  = accept && !upper && !dup;
    assign load_hi  = accept &&  upper && !dup;

    buffer_half #(.WIDTH(DATA_W)) u_lower (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .clr      (ack_full),
        .load     (load_lo),
        .data_in  (bus.res_i),
        .carry_in (bus.carry_i),
        .data     (lo_data),
        .carry    (lo_carry)
    );

    buffer_half #(.WIDTH(DATA_W)) u_upper (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .clr      (ack_full),
        .load     (load_hi),
        .data_in  (bus.res_i),
        .carry_in (bus.carry_i),
        .data     (hi_data),
        .carry    (hi_carry)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state <= S_EMPTY;
            err   <= 1'b0;
        end else begin
            case (state)
                S_EMPTY: begin
                    if (accept) state <= fill_target(upper);
                end
                S_LO: begin
                    if (accept) begin
                        if (upper) state <= S_FULL;
                        else       err   <= 1'b1;
                    end
                end
                S_HI: begin
                    if (accept) begin
                        if (!upper) state <= S_FULL;
                        else        err   <= 1'b1;
                    end
                end
                S_FULL: begin
                    // An ack empties the buffer first, so a same-cycle result starts a new word.
                    if (bus.word_ack_i) state <= accept ? fill_target(upper) : S_EMPTY;
                end
                default: state <= S_EMPTY;
            endcase
        end
    end

    assign bus.res_ready_o   = ready;
    assign bus.word_valid_o  = (state == S_FULL);
    assign bus.buff_result_o = {hi_data, lo_data};
    assign bus.carry_o       = {hi_carry, lo_carry};
    assign bus.err_o         = err;

endmodule

// File: tb/tb_result_buffer.sv
// Self-checking bench for result_buffer: fill-flag reference model on every cycle
// plus a queue of completed words compared when word_valid_o rises.
module tb_result_buffer;
    import calculator_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    result_buffer_if bus ();

    result_buffer dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;

    logic [63:0] sb_q[$];

    // Reference model state, kept as fill flags rather than an encoded state.
    logic        m_lo_f, m_hi_f, m_err;
    logic [31:0] m_lo, m_hi;
    logic [1:0]  m_carry;
    logic        prev_wv;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic check_outputs();
        logic [63:0] w;
        check_val("word_valid", bus.word_valid_o, m_lo_f && m_hi_f);
        check_val("buff_result", bus.buff_result_o, {m_hi, m_lo});
        check_val("carry", bus.carry_o, m_carry);
        check_val("err", bus.err_o, m_err);
        if (bus.word_valid_o && !prev_wv) begin
            if (sb_q.size() == 0) begin
                check_val("sb_unexpected_word", bus.word_valid_o, 1'b0);
            end else begin
                w = sb_q.pop_front();
                check_val("sb_word", bus.buff_result_o, w);
            end
        end
        prev_wv = bus.word_valid_o;
    endtask

    task automatic model_reset();
        m_lo_f = 0; m_hi_f = 0; m_err = 0;
        m_lo = 0; m_hi = 0; m_carry = 2'b00;
    endtask

    task automatic do_reset(input logic vld);
        rst = 1'b1;
        bus.res_valid_i = vld;
        bus.buffer_control_i = 1'b1;
        bus.res_i = 32'h5555_5555;
        bus.carry_i = 1'b1;
        bus.word_ack_i = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        bus.res_valid_i = 1'b0;
        model_reset();
        sb_q.delete();
        check_outputs();
        check_val("reset_ready", bus.res_ready_o, 1'b1);
    endtask

    // Drive one cycle of inputs, check ready before the edge, update the model and check after it.
    task automatic cycle(input logic vld, input logic ctl, input logic [31:0] d,
                         input logic c, input logic ack);
        logic full, rdy, acc;
        bus.res_valid_i = vld;
        bus.buffer_control_i = ctl;
        bus.res_i = d;
        bus.carry_i = c;
        bus.word_ack_i = ack;
        #3;
        full = m_lo_f && m_hi_f;
        rdy = !full || ack;
        check_val("res_ready", bus.res_ready_o, rdy);
        acc = vld && rdy;
        @(posedge clk); #1;
        if (full && ack) begin
            m_lo_f = 0; m_hi_f = 0; m_carry = 2'b00;
        end
        if (acc) begin
            if ((ctl && m_hi_f) || (!ctl && m_lo_f)) begin
                m_err = 1'b1;
            end else if (ctl) begin
                m_hi = d; m_carry[1] = c; m_hi_f = 1'b1;
            end else begin
                m_lo = d; m_carry[0] = c; m_lo_f = 1'b1;
            end
            if (m_lo_f && m_hi_f && !(full && !ack)) sb_q.push_back({m_hi, m_lo});
        end
        bus.res_valid_i = 1'b0;
        bus.word_ack_i = 1'b0;
        check_outputs();
    endtask

    initial begin
        bus.res_valid_i = 1'b0;
        bus.buffer_control_i = 1'b0;
        bus.res_i = '0;
        bus.carry_i = 1'b0;
        bus.word_ack_i = 1'b0;
        prev_wv = 1'b0;
        model_reset();
        #2;

        do_reset(1'b0);

        // Lower then upper
        cycle(1, 0, 32'h0000_0001, 0, 0);
        cycle(1, 1, 32'hDEAD_BEEF, 0, 0);
        check_val("tp_lo_hi_word", bus.buff_result_o, 64'hDEAD_BEEF_0000_0001);
        check_val("tp_lo_hi_valid", bus.word_valid_o, 1'b1);
        cycle(0, 0, 32'h0, 0, 1);
        check_val("tp_ack_valid", bus.word_valid_o, 1'b0);

        // Upper first with carry
        cycle(1, 1, 32'hFFFF_FFFF, 1, 0);
        cycle(1, 0, 32'h1234_5678, 0, 0);
        check_val("tp_hi_lo_word", bus.buff_result_o, 64'hFFFF_FFFF_1234_5678);
        check_val("tp_hi_lo_carry", bus.carry_o, 2'b10);

        // Backpressure while full
        for (int i = 0; i < 3; i++) cycle(1, i[0], 32'hBAD0_0000 + i, 1, 0);
        check_val("tp_bp_word", bus.buff_result_o, 64'hFFFF_FFFF_1234_5678);
        check_val("tp_bp_err", bus.err_o, 1'b0);

        // Ack together with a new lower result
        cycle(1, 0, 32'hAAAA_AAAA, 0, 1);
        check_val("tp_ackacc_valid", bus.word_valid_o, 1'b0);
        check_val("tp_ackacc_lo", bus.buff_result_o[31:0], 32'hAAAA_AAAA);
        check_val("tp_ackacc_carry", bus.carry_o, 2'b00);
        cycle(1, 1, 32'h0BAD_F00D, 1, 0);
        cycle(0, 0, 32'h0, 0, 1);

        // Duplicate half
        cycle(1, 0, 32'h0000_0001, 0, 0);
        cycle(1, 0, 32'h0000_0002, 1, 0);
        check_val("tp_dup_err", bus.err_o, 1'b1);
        check_val("tp_dup_lo", bus.buff_result_o[31:0], 32'h0000_0001);
        check_val("tp_dup_valid", bus.word_valid_o, 1'b0);
        cycle(1, 1, 32'h0000_0003, 0, 0);
        check_val("tp_dup_word", bus.buff_result_o, 64'h0000_0003_0000_0001);
        cycle(0, 0, 32'h0, 0, 1);
        check_val("tp_err_sticky", bus.err_o, 1'b1);

        // Reset mid-word, with a valid result presented during reset
        cycle(1, 0, 32'h7777_7777, 1, 0);
        do_reset(1'b1);
        cycle(1, 1, 32'h0102_0304, 0, 0);
        cycle(1, 0, 32'h0506_0708, 1, 0);
        check_val("tp_fresh_word", bus.buff_result_o, 64'h0102_0304_0506_0708);
        check_val("tp_fresh_carry", bus.carry_o, 2'b01);

        // Back-to-back words with same-cycle ack
        for (int i = 0; i < 6; i++) begin
            cycle(1, 0, $urandom, $urandom_range(0, 1), 1);
            cycle(1, 1, $urandom, $urandom_range(0, 1), 0);
        end
        cycle(0, 0, 32'h0, 0, 1);

        // Random traffic including stray acks and duplicates
        for (int i = 0; i < 300; i++) begin
            cycle($urandom_range(0, 3) != 0, $urandom_range(0, 1), $urandom,
                  $urandom_range(0, 1), $urandom_range(0, 2) == 0);
        end

        check_val("sb_leftover", sb_q.size(), (m_lo_f && m_hi_f && !prev_wv) ? 1 : 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
